// File: rtl/fp_issue_collect.sv
`default_nettype none
// ============================================================================
// Module      : fp_issue_collect
// Description : Issue/collect wrapper for a fixed-latency, non-stallable
//               floating-point unit. Accepts tagged operand pairs, tracks
//               in-flight operations in a valid/tag shift pipeline matched to
//               LATENCY, captures results into a FIFO, and uses credit
//               accounting so every result always finds a free FIFO entry.
//               Optional macro FP_COLLECT_BYPASS_EN: when the FIFO is empty, a
//               result is presented combinationally in its capture cycle and,
//               if accepted, never enters the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_issue_collect #(
  parameter int LATENCY   = 1,
  parameter int TAG_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [31:0]          unit_a,
  output logic [31:0]          unit_b,
  input  logic [31:0]          unit_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_q,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_cnt_w:0]   c_depth_ext = (c_cnt_w + 1)'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);

  // In-flight tracking: one valid bit and one tag per unit pipeline stage.
  logic [LATENCY-1:0]   r_vld;
  logic [TAG_WIDTH-1:0] r_tag [LATENCY];

  // Credit counters.
  logic [c_cnt_w-1:0] r_inflight;
  logic [c_cnt_w-1:0] r_occ;

  // Result FIFO storage and pointers; DEPTH is a power of two so the
  // pointers wrap naturally.
  logic [31:0]          r_mem_q   [DEPTH];
  logic [TAG_WIDTH-1:0] r_mem_tag [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;

  logic               w_fire_in;
  logic               w_capture;
  logic               w_push;
  logic               w_pop;
  logic               w_occ_nz;
  logic [c_cnt_w:0]   w_credit_used;

  assign unit_a = in_a;
  assign unit_b = in_b;

  // Credits come from registered counters only, so in_ready never depends
  // combinationally on in_valid or out_ready.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_occ};
  assign in_ready      = w_credit_used < c_depth_ext;
  assign w_fire_in     = in_valid & in_ready;
  assign w_capture     = r_vld[LATENCY-1];
  assign w_occ_nz      = (r_occ != '0);
  assign w_pop         = w_occ_nz & out_ready;
  assign busy          = (r_inflight != '0) | w_occ_nz;

`ifdef FP_COLLECT_BYPASS_EN
  logic w_bypass_show;
  assign w_bypass_show = w_capture & ~w_occ_nz;
  // A bypassed result that is taken immediately skips the FIFO entirely.
  assign w_push        = w_capture & ~(w_bypass_show & out_ready);
  assign out_valid     = w_occ_nz | w_bypass_show;

  // Output mux: FIFO head when non-empty, otherwise the live unit result.
  always_comb begin
    out_q   = '0;
    out_tag = '0;
    if (w_occ_nz) begin
      out_q   = r_mem_q[r_rd_ptr];
      out_tag = r_mem_tag[r_rd_ptr];
    end else if (w_bypass_show) begin
      out_q   = unit_q;
      out_tag = r_tag[LATENCY-1];
    end
  end
`else
  assign w_push    = w_capture;
  assign out_valid = w_occ_nz;

  // Output mux: FIFO head, forced to zero while empty so reset state is clean.
  always_comb begin
    out_q   = '0;
    out_tag = '0;
    if (w_occ_nz) begin
      out_q   = r_mem_q[r_rd_ptr];
      out_tag = r_mem_tag[r_rd_ptr];
    end
  end
`endif

  // Valid shift pipeline; clearing it on reset discards results in flight.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_fire_in;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Tag shift pipeline; tags are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    r_tag[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      r_tag[i] <= r_tag[i-1];
    end
  end

  // In-flight counter: +1 on accept, -1 on capture.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_inflight <= '0;
    end else if (w_fire_in & ~w_capture) begin
      r_inflight <= r_inflight + c_cnt_one;
    end else if (~w_fire_in & w_capture) begin
      r_inflight <= r_inflight - c_cnt_one;
    end
  end

  // Occupancy counter: +1 on FIFO write, -1 on FIFO pop.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_occ <= '0;
    end else if (w_push & ~w_pop) begin
      r_occ <= r_occ + c_cnt_one;
    end else if (~w_push & w_pop) begin
      r_occ <= r_occ - c_cnt_one;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // FIFO storage write of the captured result and its tag.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_q[r_wr_ptr]   <= unit_q;
      r_mem_tag[r_wr_ptr] <= r_tag[LATENCY-1];
    end
  end

`ifndef SYNTHESIS
  // Credits guarantee a capture never meets a full FIFO.
  a_no_capture_on_full: assert property (
    @(posedge clk) disable iff (areset) w_capture |-> (r_occ != c_depth_cnt));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_issue_collect.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_issue_collect
// Description : Self-checking bench for fp_issue_collect. A behavioural FP
//               max unit feeds the DUT; a queue-based reference model tracks
//               outstanding operations and predicts handshakes and results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_issue_collect;

  localparam int LATENCY   = 2;
  localparam int TAG_WIDTH = 8;
  localparam int DEPTH     = 4;
`ifdef FP_COLLECT_BYPASS_EN
  localparam int MIN_LAT = LATENCY;
`else
  localparam int MIN_LAT = LATENCY + 1;
`endif

  logic                 clk = 1'b0;
  logic                 areset;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_a;
  logic [31:0]          in_b;
  logic [TAG_WIDTH-1:0] in_tag;
  logic [31:0]          unit_a;
  logic [31:0]          unit_b;
  logic [31:0]          unit_q;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_q;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 busy;

  fp_issue_collect #(
    .LATENCY  (LATENCY),
    .TAG_WIDTH(TAG_WIDTH),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .unit_a   (unit_a),
    .unit_b   (unit_b),
    .unit_q   (unit_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // IEEE-754 single max via sign-magnitude to ordered-key mapping.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka;
    logic [31:0] kb;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    return (ka >= kb) ? a : b;
  endfunction

  // Behavioural fixed-latency FP unit.
  logic [31:0] upipe [LATENCY];
  always @(posedge clk) begin
    upipe[0] <= fmax(unit_a, unit_b);
    for (int i = 1; i < LATENCY; i++) upipe[i] <= upipe[i-1];
  end
  assign unit_q = upipe[LATENCY-1];

  // Reference model: every accepted op waits in order until delivered.
  typedef struct {
    logic [31:0]          q;
    logic [TAG_WIDTH-1:0] tag;
    int                   ready_cyc;
  } item_t;

  item_t                exp_q[$];
  int                   pop_cycles[$];
  logic [TAG_WIDTH-1:0] pop_tags[$];
  int                   cyc;
  int                   n_checks;
  int                   n_fail;

  logic                 obs_in_ready;
  logic                 obs_out_valid;
  logic                 obs_busy;
  logic [31:0]          obs_out_q;
  logic [TAG_WIDTH-1:0] obs_out_tag;

  // One clock cycle: sample and score outputs at negedge, then advance model.
  task automatic step();
    logic e_in_ready;
    logic e_out_valid;
    logic e_busy;
    logic fin;
    logic fout;
    @(negedge clk);
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_busy      = busy;
    obs_out_q     = out_q;
    obs_out_tag   = out_tag;
    e_in_ready  = (exp_q.size() < DEPTH);
    e_out_valid = (exp_q.size() != 0) && (exp_q[0].ready_cyc <= cyc);
    e_busy      = (exp_q.size() != 0);
    n_checks++;
    if (in_ready !== e_in_ready) begin
      n_fail++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_in_ready);
    end
    n_checks++;
    if (out_valid !== e_out_valid) begin
      n_fail++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_out_valid);
    end
    n_checks++;
    if (busy !== e_busy) begin
      n_fail++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
    end
    if (e_out_valid) begin
      n_checks++;
      if (out_q !== exp_q[0].q || out_tag !== exp_q[0].tag) begin
        n_fail++;
        $display("FAIL result cyc=%0d got q=%h tag=%h exp q=%h tag=%h",
                 cyc, out_q, out_tag, exp_q[0].q, exp_q[0].tag);
      end
    end
    fin  = in_valid & e_in_ready;
    fout = e_out_valid & out_ready;
    @(posedge clk);
    if (areset) begin
      exp_q.delete();
    end else begin
      if (fout) begin
        pop_cycles.push_back(cyc);
        pop_tags.push_back(exp_q[0].tag);
        void'(exp_q.pop_front());
      end
      if (fin) exp_q.push_back('{fmax(in_a, in_b), in_tag, cyc + MIN_LAT});
    end
    cyc++;
    #1;
  endtask

  task automatic drain(input int maxc);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < maxc && exp_q.size() != 0; k++) step();
    step();
  endtask

  task automatic clear_log();
    pop_cycles.delete();
    pop_tags.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (out_q !== 32'h0) begin n_fail++; $display("FAIL reset_out_q got=%h exp=0", out_q); end
    n_checks++;
    if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_single_op();
    int c0;
    int first;
    c0 = cyc;
    first = -1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_tag = 8'h05;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && first < 0; k++) begin
      step();
      if (obs_out_valid) first = cyc - 1;
    end
    n_checks++;
    if (first != c0 + MIN_LAT) begin
      n_fail++; $display("FAIL single_latency got=%0d exp=%0d", first - c0, MIN_LAT);
    end
    n_checks++;
    if (obs_out_q !== 32'h4000_0000 || obs_out_tag !== 8'h05) begin
      n_fail++; $display("FAIL single_result got q=%h tag=%h exp q=40000000 tag=05", obs_out_q, obs_out_tag);
    end
    step();
    n_checks++;
    if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_pop got=%b exp=0", obs_busy); end
  endtask

  task automatic test_streaming();
    clear_log();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_tag = TAG_WIDTH'(i);
      step();
      n_checks++;
      if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready op=%0d got=%b exp=1", i, obs_in_ready); end
    end
    drain(40);
    n_checks++;
    if (pop_tags.size() != 20) begin
      n_fail++; $display("FAIL stream_count got=%0d exp=20", pop_tags.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_checks++;
        if (pop_tags[i] !== TAG_WIDTH'(i) || pop_cycles[i] != pop_cycles[0] + i) begin
          n_fail++; $display("FAIL stream_order idx=%0d got tag=%h cyc=%0d exp tag=%h cyc=%0d",
                             i, pop_tags[i], pop_cycles[i], TAG_WIDTH'(i), pop_cycles[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int accepted;
    logic [31:0]          head_q;
    logic [TAG_WIDTH-1:0] head_tag;
    clear_log();
    accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_tag = TAG_WIDTH'(8'h10 + i);
      step();
      if (obs_in_ready) begin accepted++; end
      else in_tag = in_tag;
    end
    in_valid = 1'b0;
    n_checks++;
    if (accepted != 4) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=4", accepted); end
    step();
    head_q = obs_out_q; head_tag = obs_out_tag;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      step();
      n_checks++;
      if (obs_in_ready !== 1'b0 || obs_out_q !== head_q || obs_out_tag !== head_tag) begin
        n_fail++; $display("FAIL bp_hold got in_ready=%b q=%h tag=%h exp in_ready=0 q=%h tag=%h",
                           obs_in_ready, obs_out_q, obs_out_tag, head_q, head_tag);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_credit_return got=%b exp=1", obs_in_ready); end
    drain(20);
    n_checks++;
    if (pop_tags.size() != 4) begin
      n_fail++; $display("FAIL bp_count got=%0d exp=4", pop_tags.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (pop_tags[i] !== TAG_WIDTH'(8'h10 + i)) begin
          n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, pop_tags[i], TAG_WIDTH'(8'h10 + i));
        end
      end
    end
  endtask

  task automatic test_full_pop_capture();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_tag = TAG_WIDTH'(8'h20 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    n_checks++;
    if (obs_out_valid !== 1'b1 || obs_in_ready !== 1'b1 || obs_out_tag !== TAG_WIDTH'(8'h21)) begin
      n_fail++; $display("FAIL full_pop_capture got valid=%b in_ready=%b tag=%h exp valid=1 in_ready=1 tag=21",
                         obs_out_valid, obs_in_ready, obs_out_tag);
    end
    drain(20);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_tag = 8'hA1;
    step();
    in_tag = 8'hA2;
    step();
    in_valid = 1'b0;
    areset = 1'b1;
    step();
    areset = 1'b0;
    step();
    n_checks++;
    if (obs_out_valid !== 1'b0 || obs_busy !== 1'b0 || obs_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid got valid=%b busy=%b in_ready=%b exp 0 0 1",
                         obs_out_valid, obs_busy, obs_in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (obs_out_valid !== 1'b0 || obs_out_tag === 8'hA1 || obs_out_tag === 8'hA2) begin
        n_fail++; $display("FAIL reset_ghost cyc=%0d got valid=%b tag=%h exp valid=0", cyc - 1, obs_out_valid, obs_out_tag);
      end
    end
  endtask

  task automatic test_mixed_sign();
    int seen;
    seen = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'hBF80_0000; in_b = 32'h0000_0000; in_tag = 8'h3C;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      step();
      if (obs_out_valid) seen = 1;
    end
    n_checks++;
    if (seen == 0 || obs_out_q !== 32'h0 || obs_out_tag !== 8'h3C) begin
      n_fail++; $display("FAIL mixed_sign got seen=%0d q=%h tag=%h exp q=00000000 tag=3c", seen, obs_out_q, obs_out_tag);
    end
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 65);
      in_a   = $urandom;
      in_b   = $urandom;
      in_tag = TAG_WIDTH'($urandom);
      step();
    end
    drain(30);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_drain left=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    areset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    test_reset();
    test_single_op();
    test_streaming();
    test_backpressure();
    test_full_pop_capture();
    test_reset_midflight();
    test_mixed_sign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
